// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: sequencer for a cascade of BRAM line-delay stages.
// Measures the active line length, programs h_size, gates dl_ce/dl_rst,
// tracks x/y position and flags when the pixel context window is populated.
// Optional feature: define DLC_FRAME_STATS_EN to add the frame_lines output.
module delay_line_ctrl #(
  parameter int BRAM_SIZE_W = 10,
  parameter int LINES       = 2,
  parameter int CTX_W       = 3,
  parameter int Y_W         = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   de_in,
  input  logic                   vsync_in,
  output logic                   dl_ce,
  output logic                   dl_rst,
  output logic [BRAM_SIZE_W-1:0] h_size,
  output logic [BRAM_SIZE_W-1:0] x_pos,
  output logic [Y_W-1:0]         y_pos,
  output logic                   ctx_valid,
  output logic                   len_err
`ifdef DLC_FRAME_STATS_EN
  ,
  output logic [Y_W-1:0]         frame_lines
`endif
);

  localparam logic [BRAM_SIZE_W-1:0] X_MAX     = {BRAM_SIZE_W{1'b1}};
  localparam logic [Y_W-1:0]         Y_MAX     = {Y_W{1'b1}};
  localparam logic [Y_W-1:0]         LINES_Y   = Y_W'(LINES);
  localparam logic [Y_W-1:0]         LAST_FILL = Y_W'(LINES - 1);
  localparam logic [BRAM_SIZE_W-1:0] CTX_LAST  = BRAM_SIZE_W'(CTX_W - 1);
  localparam logic [BRAM_SIZE_W-1:0] CTX_MIN   = BRAM_SIZE_W'(CTX_W);

  typedef enum logic [2:0] {IDLE, FLUSH, MEASURE, FILL, RUN} state_t;

  state_t                 state_q, state_d;
  logic [BRAM_SIZE_W-1:0] h_size_q, h_size_d;
  logic [BRAM_SIZE_W-1:0] x_pos_q, x_pos_d;
  logic [Y_W-1:0]         y_pos_q, y_pos_d;
  logic                   ctx_valid_q, ctx_valid_d;
  logic                   len_err_q, len_err_d;
  logic                   de_prev_q, de_prev_d;
  logic                   line_end;

  // Next-state, counters, length checks and delay-line gating.
  always_comb begin
    state_d     = state_q;
    h_size_d    = h_size_q;
    x_pos_d     = x_pos_q;
    y_pos_d     = y_pos_q;
    len_err_d   = len_err_q;
    de_prev_d   = 1'b0;
    ctx_valid_d = 1'b0;
    dl_ce       = 1'b0;
    dl_rst      = 1'b0;
    line_end    = 1'b0;

    case (state_q)
      IDLE: begin
        x_pos_d = '0;
      end
      FLUSH: begin
        dl_ce     = 1'b1;
        dl_rst    = 1'b1;
        x_pos_d   = '0;
        y_pos_d   = '0;
        len_err_d = 1'b0;
        state_d   = MEASURE;
      end
      MEASURE, FILL, RUN: begin
        dl_ce     = de_in;
        de_prev_d = de_in;
        line_end  = de_prev_q && !de_in;
        if (de_in) begin
          x_pos_d = (x_pos_q == X_MAX) ? x_pos_q : x_pos_q + 1'b1;
        end else begin
          x_pos_d = '0;
        end
        ctx_valid_d = de_in && (state_q == RUN) && (y_pos_q >= LINES_Y) &&
                      (x_pos_q >= CTX_LAST);
        if ((state_q == MEASURE) && de_in && (x_pos_q == X_MAX)) begin
          len_err_d = 1'b1;
          h_size_d  = X_MAX;
        end
        if (line_end) begin
          if (state_q == MEASURE) begin
            if (x_pos_q < CTX_MIN) begin
              len_err_d = 1'b1;
            end else begin
              h_size_d = x_pos_q;
              y_pos_d  = Y_W'(1);
              state_d  = (LINES == 1) ? RUN : FILL;
            end
          end else begin
            if (x_pos_q != h_size_q) begin
              len_err_d = 1'b1;
            end
            y_pos_d = (y_pos_q == Y_MAX) ? y_pos_q : y_pos_q + 1'b1;
            if ((state_q == FILL) && (y_pos_q >= LAST_FILL)) begin
              state_d = RUN;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (vsync_in) begin
      state_d     = FLUSH;
      x_pos_d     = '0;
      y_pos_d     = '0;
      len_err_d   = 1'b0;
      de_prev_d   = 1'b0;
      ctx_valid_d = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      h_size_q    <= '0;
      x_pos_q     <= '0;
      y_pos_q     <= '0;
      ctx_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
      de_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_size_q    <= h_size_d;
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      ctx_valid_q <= ctx_valid_d;
      len_err_q   <= len_err_d;
      de_prev_q   <= de_prev_d;
    end
  end

  assign h_size    = h_size_q;
  assign x_pos     = x_pos_q;
  assign y_pos     = y_pos_q;
  assign ctx_valid = ctx_valid_q;
  assign len_err   = len_err_q;

`ifdef DLC_FRAME_STATS_EN
  logic [Y_W-1:0] frame_lines_q, frame_lines_d;

  // Capture the line count of a frame that reached FILL or RUN.
  always_comb begin
    frame_lines_d = frame_lines_q;
    if (vsync_in && ((state_q == RUN) || (state_q == FILL))) begin
      frame_lines_d = y_pos_q;
    end
  end

  // Frame line-count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_lines_q <= '0;
    end else begin
      frame_lines_q <= frame_lines_d;
    end
  end

  assign frame_lines = frame_lines_q;
`endif

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl. A second instance with a 4-bit line
// counter shares the stimulus so saturation of the measured length is covered.
module tb_delay_line_ctrl;

  logic        clk;
  logic        rst;
  logic        de_in;
  logic        vsync_in;
  logic        dl_ce, dl_rst, ctx_valid, len_err;
  logic [9:0]  h_size, x_pos;
  logic [10:0] y_pos;
  logic        dl_ce4, dl_rst4, ctx_valid4, len_err4;
  logic [3:0]  h_size4, x_pos4;
  logic [10:0] y_pos4;
`ifdef DLC_FRAME_STATS_EN
  logic [10:0] frame_lines, frame_lines4;
`endif

  int testsRun;
  int testsFailed;

  // Default-parameter instance.
  delay_line_ctrl #(.BRAM_SIZE_W(10), .LINES(2), .CTX_W(3), .Y_W(11)) dut (
    .clk(clk), .rst(rst), .de_in(de_in), .vsync_in(vsync_in),
    .dl_ce(dl_ce), .dl_rst(dl_rst), .h_size(h_size), .x_pos(x_pos),
    .y_pos(y_pos), .ctx_valid(ctx_valid), .len_err(len_err)
`ifdef DLC_FRAME_STATS_EN
    , .frame_lines(frame_lines)
`endif
  );

  // Narrow-counter instance; maximum line length 15.
  delay_line_ctrl #(.BRAM_SIZE_W(4), .LINES(2), .CTX_W(3), .Y_W(11)) dut4 (
    .clk(clk), .rst(rst), .de_in(de_in), .vsync_in(vsync_in),
    .dl_ce(dl_ce4), .dl_rst(dl_rst4), .h_size(h_size4), .x_pos(x_pos4),
    .y_pos(y_pos4), .ctx_valid(ctx_valid4), .len_err(len_err4)
`ifdef DLC_FRAME_STATS_EN
    , .frame_lines(frame_lines4)
`endif
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then wait until just after the clock edge.
  task automatic applyStimulus(input logic de, input logic vs);
    de_in    = de;
    vsync_in = vs;
    @(posedge clk);
    #1;
  endtask

  // A line of n pixels followed by gap idle cycles.
  task automatic applyLine(input int n, input int gap);
    repeat (n) applyStimulus(1'b1, 1'b0);
    repeat (gap) applyStimulus(1'b0, 1'b0);
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Directed sequence.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    de_in       = 1'b0;
    vsync_in    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_dl_ce", 32'(dl_ce), 32'd0);
    checkOutput("rst_dl_rst", 32'(dl_rst), 32'd0);
    checkOutput("rst_h_size", 32'(h_size), 32'd0);
    checkOutput("rst_x_pos", 32'(x_pos), 32'd0);
    checkOutput("rst_y_pos", 32'(y_pos), 32'd0);
    checkOutput("rst_ctx_valid", 32'(ctx_valid), 32'd0);
    checkOutput("rst_len_err", 32'(len_err), 32'd0);
`ifdef DLC_FRAME_STATS_EN
    checkOutput("rst_frame_lines", 32'(frame_lines), 32'd0);
`endif
    rst = 1'b0;

    // Three 8-pixel lines: measure, fill, then first run line.
    applyStimulus(1'b0, 1'b1);
    checkOutput("t1_flush_ce", 32'(dl_ce), 32'd1);
    checkOutput("t1_flush_rst", 32'(dl_rst), 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_measure_ce_idle", 32'(dl_ce), 32'd0);
    checkOutput("t1_measure_rst", 32'(dl_rst), 32'd0);
    applyLine(8, 0);
    checkOutput("t1_x_end", 32'(x_pos), 32'd8);
    checkOutput("t1_ce_pixel", 32'(dl_ce), 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_h_size", 32'(h_size), 32'd8);
    checkOutput("t1_y_line0", 32'(y_pos), 32'd1);
    checkOutput("t1_x_return", 32'(x_pos), 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyLine(8, 4);
    checkOutput("t1_y_line1", 32'(y_pos), 32'd2);
    checkOutput("t1_ctx_before", 32'(ctx_valid), 32'd0);
    repeat (2) applyStimulus(1'b1, 1'b0);
    checkOutput("t1_ctx_x1", 32'(ctx_valid), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_ctx_x2", 32'(ctx_valid), 32'd1);
    checkOutput("t1_x3", 32'(x_pos), 32'd3);
    repeat (5) applyStimulus(1'b1, 1'b0);
    checkOutput("t1_ctx_x7", 32'(ctx_valid), 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_ctx_gap", 32'(ctx_valid), 32'd0);
    checkOutput("t1_y_line2", 32'(y_pos), 32'd3);
    checkOutput("t1_len_err", 32'(len_err), 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b0);

    // Short line in RUN sets the sticky error; vsync clears it.
    applyLine(7, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t2_len_err_set", 32'(len_err), 32'd1);
    checkOutput("t2_h_size_kept", 32'(h_size), 32'd8);
    checkOutput("t2_y", 32'(y_pos), 32'd4);
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyLine(8, 4);
    checkOutput("t2_len_err_sticky", 32'(len_err), 32'd1);
    checkOutput("t2_y_next", 32'(y_pos), 32'd5);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t2_len_err_clear", 32'(len_err), 32'd0);
    checkOutput("t2_flush_rst", 32'(dl_rst), 32'd1);
    checkOutput("t2_y_clear", 32'(y_pos), 32'd0);
`ifdef DLC_FRAME_STATS_EN
    checkOutput("t2_frame_lines", 32'(frame_lines), 32'd5);
`endif

    // Vsync in the middle of line 1, then a re-measured 6-pixel frame.
    applyStimulus(1'b0, 1'b0);
    applyLine(8, 4);
    applyLine(4, 0);
    checkOutput("t3_x_mid", 32'(x_pos), 32'd4);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t3_flush_ce", 32'(dl_ce), 32'd1);
    checkOutput("t3_flush_rst", 32'(dl_rst), 32'd1);
    checkOutput("t3_x_zero", 32'(x_pos), 32'd0);
    checkOutput("t3_y_zero", 32'(y_pos), 32'd0);
`ifdef DLC_FRAME_STATS_EN
    checkOutput("t3_frame_lines_fill", 32'(frame_lines), 32'd1);
`endif
    applyStimulus(1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0);
    applyLine(6, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t3_h_size", 32'(h_size), 32'd6);
    checkOutput("t3_y", 32'(y_pos), 32'd1);
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyLine(6, 4);
    applyLine(6, 4);
    applyLine(6, 4);
    checkOutput("t3_y_frame", 32'(y_pos), 32'd4);
    checkOutput("t3_len_err", 32'(len_err), 32'd0);
    applyStimulus(1'b0, 1'b1);
`ifdef DLC_FRAME_STATS_EN
    checkOutput("t3_frame_lines_run", 32'(frame_lines), 32'd4);
`endif

    // 20-pixel first line: saturates the 4-bit instance only.
    applyStimulus(1'b0, 1'b0);
    repeat (17) applyStimulus(1'b1, 1'b0);
    checkOutput("t4_x4_sat", 32'(x_pos4), 32'd15);
    checkOutput("t4_x_wide", 32'(x_pos), 32'd17);
    checkOutput("t4_len_err4_early", 32'(len_err4), 32'd1);
    repeat (3) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4_h_size4", 32'(h_size4), 32'd15);
    checkOutput("t4_len_err4", 32'(len_err4), 32'd1);
    checkOutput("t4_h_size", 32'(h_size), 32'd20);
    checkOutput("t4_len_err", 32'(len_err), 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_len_err4_clear", 32'(len_err4), 32'd0);
    applyStimulus(1'b0, 1'b0);

    // Too-short first line is rejected; the next valid line is measured.
    applyLine(2, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_len_err", 32'(len_err), 32'd1);
    checkOutput("t5_h_size_kept", 32'(h_size), 32'd20);
    checkOutput("t5_y_stay", 32'(y_pos), 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyLine(5, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_h_size", 32'(h_size), 32'd5);
    checkOutput("t5_h_size4", 32'(h_size4), 32'd5);
    checkOutput("t5_y", 32'(y_pos), 32'd1);
    checkOutput("t5_len_err_sticky", 32'(len_err), 32'd1);
    repeat (3) applyStimulus(1'b0, 1'b0);

    // Asynchronous reset in the middle of a RUN line.
    applyLine(5, 4);
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("t6_ctx_pre", 32'(ctx_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("t6_dl_ce", 32'(dl_ce), 32'd0);
    checkOutput("t6_h_size", 32'(h_size), 32'd0);
    checkOutput("t6_x_pos", 32'(x_pos), 32'd0);
    checkOutput("t6_y_pos", 32'(y_pos), 32'd0);
    checkOutput("t6_ctx_valid", 32'(ctx_valid), 32'd0);
    checkOutput("t6_len_err", 32'(len_err), 32'd0);
`ifdef DLC_FRAME_STATS_EN
    checkOutput("t6_frame_lines", 32'(frame_lines), 32'd0);
`endif
    #2;
    rst = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("t6_idle_x", 32'(x_pos), 32'd0);
    checkOutput("t6_idle_ce", 32'(dl_ce), 32'd0);
    checkOutput("t6_idle_y", 32'(y_pos), 32'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t6_vsync_flush", 32'(dl_rst), 32'd1);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
